matrix_operand_loader: RTL and testbench

Serial-to-parallel front end for MatrixMul. Accepts matrix elements one per handshake on a narrow stream, assembles the packed AI and BI operand buses, and presents them with a valid/ready handshake. The combinational multiplier directly downstream sees AI/BI held stable for the whole time op_valid is high. The loader handles framing, error detection, backpressure and frame counting.

---
 rtl/matrix_operand_loader_pkg.sv | 11 +
 rtl/matrix_operand_loader.sv | 132 +++++++++++++
 tb/tb_matrix_operand_loader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/matrix_operand_loader_pkg.sv
// Shared helpers for the matrix operand loader: counter type and slot bit-offset math.
package matrix_operand_loader_pkg;

  typedef logic [15:0] frame_cnt_t;

  // LSB position of a flat element slot inside a packed 2D operand bus.
  function automatic int slot_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/matrix_operand_loader.sv
// Serial-to-parallel loader: assembles packed A/B operands from an element stream
// and holds them stable for a downstream combinational multiplier.
module matrix_operand_loader
  import matrix_operand_loader_pkg::*;
#(
  parameter int bitlength = 8,
  parameter int M1_D1     = 3,
  parameter int M1_D2     = 4,
  parameter int M2_D2     = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [bitlength-1:0]               s_data,
  input  logic                               s_last,
  output logic [M1_D1*M1_D2*bitlength-1:0]   AI,
  output logic [M1_D2*M2_D2*bitlength-1:0]   BI,
  output logic                               op_valid,
  input  logic                               op_ready,
  output logic                               err,
  output logic [15:0]                        frame_cnt
);

  localparam int NA = M1_D1 * M1_D2;
  localparam int NB = M1_D2 * M2_D2;
  localparam int N  = NA + NB;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  typedef enum logic {LOAD = 1'b0, HOLD = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    s_ready_q, s_ready_d;
  logic                    op_valid_q, op_valid_d;
  logic                    err_q, err_d;
  frame_cnt_t              frame_cnt_q, frame_cnt_d;
  logic [NA*bitlength-1:0] ai_q, ai_d;
  logic [NB*bitlength-1:0] bi_q, bi_d;
  logic                    accept;

  // s_ready_q is only high in LOAD, so this also blocks writes while operands are held.
  assign accept = s_valid && s_ready_q && !clear;

  genvar gi;
  generate
    for (gi = 0; gi < NA; gi++) begin : g_a_slot
      assign ai_d[slot_lsb(gi, bitlength) +: bitlength] =
        (accept && idx_q == IW'(gi)) ? s_data : ai_q[slot_lsb(gi, bitlength) +: bitlength];
    end
    for (gi = 0; gi < NB; gi++) begin : g_b_slot
      assign bi_d[slot_lsb(gi, bitlength) +: bitlength] =
        (accept && idx_q == IW'(NA + gi)) ? s_data : bi_q[slot_lsb(gi, bitlength) +: bitlength];
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    s_ready_d   = s_ready_q;
    op_valid_d  = op_valid_q;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    if (clear) begin
      state_d    = LOAD;
      idx_d      = '0;
      op_valid_d = 1'b0;
      s_ready_d  = 1'b1;
    end else begin
      case (state_q)
        LOAD: begin
          s_ready_d = 1'b1;
          if (accept) begin
            if (idx_q == IDX_LAST && s_last) begin
              state_d     = HOLD;
              idx_d       = '0;
              s_ready_d   = 1'b0;
              op_valid_d  = 1'b1;
              frame_cnt_d = frame_cnt_q + 16'd1;
            end else if (s_last || idx_q == IDX_LAST) begin
              err_d = 1'b1;
              idx_d = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end
        end
        HOLD: begin
          if (op_ready) begin
            state_d    = LOAD;
            idx_d      = '0;
            op_valid_d = 1'b0;
            s_ready_d  = 1'b1;
          end
        end
        default: state_d = LOAD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      s_ready_q   <= 1'b0;
      op_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      ai_q        <= '0;
      bi_q        <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      s_ready_q   <= s_ready_d;
      op_valid_q  <= op_valid_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      ai_q        <= ai_d;
      bi_q        <= bi_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign op_valid  = op_valid_q;
  assign err       = err_q;
  assign frame_cnt = frame_cnt_q;
  assign AI        = ai_q;
  assign BI        = bi_q;

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader: framing, backpressure, errors, clear and async reset.
module tb_matrix_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [95:0] AI;
  logic [63:0] BI;
  logic        op_valid;
  logic        op_ready;
  logic        err;
  logic [15:0] frame_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  matrix_operand_loader #(.bitlength(8), .M1_D1(3), .M1_D2(4), .M2_D2(2)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .AI(AI), .BI(BI), .op_valid(op_valid), .op_ready(op_ready),
    .err(err), .frame_cnt(frame_cnt)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected packed A: slot k holds base+k (row-major stream order).
  function automatic logic [95:0] exp_ai(input int base);
    logic [95:0] v = '0;
    for (int k = 0; k < 12; k++) v[k*8 +: 8] = 8'(base + k);
    return v;
  endfunction

  function automatic logic [63:0] exp_bi(input int base);
    logic [63:0] v = '0;
    for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(base + 12 + k);
    return v;
  endfunction

  // Called #1 after an edge; returns #1 after the accepting edge with s_valid dropped.
  task automatic send(input logic [7:0] v, input logic last, input int gap);
    int guard = 0;
    if (gap > 0) begin
      s_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = v;
    s_last  = last;
    while (!s_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) chk("send_timeout", 96'(s_ready), 96'(1));
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int base, input int max_gap);
    for (int k = 0; k < 20; k++)
      send(8'(base + k), (k == 19), (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic consume();
    op_ready = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0;
  endtask

  logic [95:0] ai_snap;
  logic [63:0] bi_snap;
  int          c11;

  initial begin
    rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; op_ready = 1'b0;
    #1;
    chk("rst_op_valid", 96'(op_valid), 96'(0));
    chk("rst_s_ready", 96'(s_ready), 96'(0));
    chk("rst_AI", AI, 96'(0));
    chk("rst_BI", 96'(BI), 96'(0));
    chk("rst_frame_cnt", 96'(frame_cnt), 96'(0));
    chk("rst_err", 96'(err), 96'(0));
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("s_ready_after_release", 96'(s_ready), 96'(1));

    // Frame 1: values 1..20 back-to-back.
    send_frame(1, 0);
    chk("f1_op_valid", 96'(op_valid), 96'(1));
    chk("f1_s_ready", 96'(s_ready), 96'(0));
    chk("f1_AI", AI, exp_ai(1));
    chk("f1_BI", 96'(BI), 96'(exp_bi(1)));
    chk("f1_A11", 96'(AI[7:0]), 96'(1));
    chk("f1_A34", 96'(AI[95:88]), 96'(12));
    chk("f1_B11", 96'(BI[7:0]), 96'(13));
    chk("f1_B42", 96'(BI[63:56]), 96'(20));
    chk("f1_frame_cnt", 96'(frame_cnt), 96'(1));
    c11 = 0;
    for (int k = 0; k < 4; k++) c11 += int'(AI[k*8 +: 8]) * int'(BI[(k*2)*8 +: 8]);
    chk("f1_C11", 96'(c11), 96'(170));

    // Backpressure: downstream stalls while the stream keeps offering data.
    ai_snap = AI; bi_snap = BI;
    s_valid = 1'b1; s_data = 8'hFF; s_last = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_s_ready", 96'(s_ready), 96'(0));
      chk("bp_op_valid", 96'(op_valid), 96'(1));
      chk("bp_AI_stable", AI, ai_snap);
      chk("bp_BI_stable", 96'(BI), 96'(bi_snap));
    end
    s_valid = 1'b0; s_last = 1'b0;
    consume();
    chk("bp_release_op_valid", 96'(op_valid), 96'(0));
    chk("bp_release_s_ready", 96'(s_ready), 96'(1));
    chk("bp_release_frame_cnt", 96'(frame_cnt), 96'(1));

    // Early s_last on element 7.
    for (int k = 1; k <= 6; k++) send(8'(k), 1'b0, 0);
    send(8'd7, 1'b1, 0);
    chk("early_err", 96'(err), 96'(1));
    chk("early_op_valid", 96'(op_valid), 96'(0));
    @(posedge clk); #1;
    chk("early_err_one_cycle", 96'(err), 96'(0));
    chk("early_frame_cnt", 96'(frame_cnt), 96'(1));
    send_frame(1, 0);
    chk("early_recover_op_valid", 96'(op_valid), 96'(1));
    chk("early_recover_AI", AI, exp_ai(1));
    chk("early_recover_BI", 96'(BI), 96'(exp_bi(1)));
    chk("early_recover_frame_cnt", 96'(frame_cnt), 96'(2));
    consume();

    // Missing s_last on element 20.
    for (int k = 1; k <= 20; k++) send(8'(k), 1'b0, 0);
    chk("miss_err", 96'(err), 96'(1));
    chk("miss_op_valid", 96'(op_valid), 96'(0));
    chk("miss_s_ready", 96'(s_ready), 96'(1));
    @(posedge clk); #1;
    chk("miss_err_one_cycle", 96'(err), 96'(0));
    send_frame(101, 0);
    chk("miss_recover_op_valid", 96'(op_valid), 96'(1));
    chk("miss_recover_AI", AI, exp_ai(101));
    chk("miss_recover_BI", 96'(BI), 96'(exp_bi(101)));
    chk("miss_recover_frame_cnt", 96'(frame_cnt), 96'(3));
    consume();

    // clear after 10 accepts, with random valid gaps; clear wins over a concurrent offer.
    for (int k = 0; k < 10; k++) send(8'(50 + k), 1'b0, int'($urandom_range(0, 2)));
    s_valid = 1'b1; s_data = 8'hEE; s_last = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; s_valid = 1'b0;
    chk("clr_op_valid", 96'(op_valid), 96'(0));
    chk("clr_s_ready", 96'(s_ready), 96'(1));
    chk("clr_err", 96'(err), 96'(0));
    send_frame(200, 2);
    chk("clr_frame_op_valid", 96'(op_valid), 96'(1));
    chk("clr_frame_AI", AI, exp_ai(200));
    chk("clr_frame_BI", 96'(BI), 96'(exp_bi(200)));
    chk("clr_frame_cnt", 96'(frame_cnt), 96'(4));

    // clear in HOLD (with op_ready high) drops the frame without recounting or touching operands.
    op_ready = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    op_ready = 1'b0; clear = 1'b0;
    chk("clr_hold_op_valid", 96'(op_valid), 96'(0));
    chk("clr_hold_s_ready", 96'(s_ready), 96'(1));
    chk("clr_hold_frame_cnt", 96'(frame_cnt), 96'(4));
    chk("clr_hold_AI", AI, exp_ai(200));

    // Async reset mid-HOLD.
    send_frame(1, 0);
    chk("pre_rst_op_valid", 96'(op_valid), 96'(1));
    chk("pre_rst_frame_cnt", 96'(frame_cnt), 96'(5));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_op_valid", 96'(op_valid), 96'(0));
    chk("arst_s_ready", 96'(s_ready), 96'(0));
    chk("arst_AI", AI, 96'(0));
    chk("arst_BI", 96'(BI), 96'(0));
    chk("arst_frame_cnt", 96'(frame_cnt), 96'(0));
    @(posedge clk); #2;
    rst_n = 1'b1;
    chk("arst_s_ready_before_edge", 96'(s_ready), 96'(0));
    @(posedge clk); #1;
    chk("arst_s_ready_after_edge", 96'(s_ready), 96'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
